// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic PE family.
package systolic_pkg;

    typedef enum logic {
        PE_IDLE  = 1'b0,
        PE_ACCUM = 1'b1
    } pe_state_e;

    function automatic int prod_width(input int uw);
        return 2 * uw;
    endfunction

endpackage

// File: rtl/systolic_mult.sv
// Combinational unsigned UWIDTH x UWIDTH array multiplier: AND partial products
// summed by one adder row per multiplier bit.
module systolic_mult
    import systolic_pkg::*;
#(
    parameter int UWIDTH = 4
) (
    input  logic [UWIDTH-1:0]               i_a,
    input  logic [UWIDTH-1:0]               i_b,
    output logic [prod_width(UWIDTH)-1:0]   o_p
);

    localparam int PW = prod_width(UWIDTH);

    logic [UWIDTH-1:0][PW-1:0] w_pp;
    logic [UWIDTH:0][PW-1:0]   w_row;

    assign w_row[0] = '0;

    for (genvar i = 0; i < UWIDTH; i++) begin : g_row
        assign w_pp[i]      = PW'({UWIDTH{i_b[i]}} & i_a) << i;
        assign w_row[i+1]   = w_row[i] + w_pp[i];
    end

    assign o_p = w_row[UWIDTH];

endmodule

// File: rtl/systolic_pe.sv
// Output-stationary unsigned MAC processing element with in-band dot-product framing.
// Build option SYSTOLIC_PE_SAT_EN: saturate the accumulator instead of wrapping.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int UWIDTH = 4,
    parameter int BWIDTH = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [UWIDTH-1:0] north,
    input  logic              north_vld,
    input  logic [UWIDTH-1:0] west,
    input  logic              west_vld,
    input  logic              west_clr,
    input  logic              west_last,
    output logic [UWIDTH-1:0] south,
    output logic              south_vld,
    output logic [UWIDTH-1:0] east,
    output logic              east_vld,
    output logic              east_clr,
    output logic              east_last,
    output logic [BWIDTH-1:0] mac,
    output logic              mac_vld,
    output logic              mac_ovf
);

    localparam int PW = prod_width(UWIDTH);

    if (BWIDTH < PW) begin : g_bad_width
        $error("systolic_pe: BWIDTH (%0d) must be >= 2*UWIDTH (%0d)", BWIDTH, PW);
    end

    logic [PW-1:0]     w_prod;
    pe_state_e         r_state;
    pe_state_e         w_state_nxt;
    logic [BWIDTH-1:0] r_acc;
    logic [BWIDTH-1:0] w_acc_nxt;
    logic              r_ovf_acc;
    logic              w_ovf_nxt;
    logic              w_fire;
    logic              w_restart;
    logic [BWIDTH-1:0] w_base;
    logic [BWIDTH:0]   w_sum;
    logic              w_wrap;
    logic              w_ovf_beat;
    logic [BWIDTH-1:0] w_beat_val;
    logic              w_mac_ld;

    systolic_mult #(
        .UWIDTH (UWIDTH)
    ) u_mult (
        .i_a (north),
        .i_b (west),
        .o_p (w_prod)
    );

    assign w_fire     = north_vld & west_vld;
    assign w_restart  = (r_state == PE_IDLE) | west_clr;
    assign w_base     = w_restart ? '0 : r_acc;
    assign w_sum      = {1'b0, w_base} + (BWIDTH+1)'(w_prod);
    assign w_wrap     = w_sum[BWIDTH];
    // Sticky history only carries over when this beat continues the same dot product.
    assign w_ovf_beat = w_wrap | (~w_restart & r_ovf_acc);

`ifdef SYSTOLIC_PE_SAT_EN
    assign w_beat_val = w_ovf_beat ? '1 : w_sum[BWIDTH-1:0];
`else
    assign w_beat_val = w_sum[BWIDTH-1:0];
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_ovf_nxt   = r_ovf_acc;
        w_mac_ld    = 1'b0;
        if (w_fire) begin
            if (west_last) begin
                w_state_nxt = PE_IDLE;
                w_acc_nxt   = '0;
                w_ovf_nxt   = 1'b0;
                w_mac_ld    = 1'b1;
            end else begin
                w_state_nxt = PE_ACCUM;
                w_acc_nxt   = w_beat_val;
                w_ovf_nxt   = w_ovf_beat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= PE_IDLE;
            r_acc     <= '0;
            r_ovf_acc <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_acc     <= w_acc_nxt;
            r_ovf_acc <= w_ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mac     <= '0;
            mac_ovf <= 1'b0;
            mac_vld <= 1'b0;
        end else begin
            mac_vld <= w_mac_ld;
            if (w_mac_ld) begin
                mac     <= w_beat_val;
                mac_ovf <= w_ovf_beat;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            south     <= '0;
            south_vld <= 1'b0;
            east      <= '0;
            east_vld  <= 1'b0;
            east_clr  <= 1'b0;
            east_last <= 1'b0;
        end else begin
            south     <= north;
            south_vld <= north_vld;
            east      <= west;
            east_vld  <= west_vld;
            east_clr  <= west_clr;
            east_last <= west_last;
        end
    end

endmodule

// File: tb/tb_systolic_pe.sv
// Self-checking bench for systolic_pe: a 4x16 instance under a vector table and
// an 4x8 instance sharing the same stimulus for the overflow corner.
module tb_systolic_pe;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] north, west;
    logic       north_vld, west_vld, west_clr, west_last;

    logic [3:0]  south, east;
    logic        south_vld, east_vld, east_clr, east_last;
    logic [15:0] mac;
    logic        mac_vld, mac_ovf;

    logic [3:0]  s8_south, s8_east;
    logic        s8_south_vld, s8_east_vld, s8_east_clr, s8_east_last;
    logic [7:0]  s8_mac;
    logic        s8_mac_vld, s8_mac_ovf;

    always #5 clk = ~clk;

    systolic_pe #(.UWIDTH(4), .BWIDTH(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .north(north), .north_vld(north_vld),
        .west(west), .west_vld(west_vld), .west_clr(west_clr), .west_last(west_last),
        .south(south), .south_vld(south_vld),
        .east(east), .east_vld(east_vld), .east_clr(east_clr), .east_last(east_last),
        .mac(mac), .mac_vld(mac_vld), .mac_ovf(mac_ovf)
    );

    systolic_pe #(.UWIDTH(4), .BWIDTH(8)) dut8 (
        .clk(clk), .reset_n(reset_n),
        .north(north), .north_vld(north_vld),
        .west(west), .west_vld(west_vld), .west_clr(west_clr), .west_last(west_last),
        .south(s8_south), .south_vld(s8_south_vld),
        .east(s8_east), .east_vld(s8_east_vld), .east_clr(s8_east_clr), .east_last(s8_east_last),
        .mac(s8_mac), .mac_vld(s8_mac_vld), .mac_ovf(s8_mac_ovf)
    );

    typedef struct {
        logic [3:0]  n;
        bit          nv;
        logic [3:0]  w;
        bit          wv;
        bit          clr;
        bit          last;
        logic [15:0] exp_mac;
        bit          exp_ovf;
    } vec_t;

    typedef struct {
        logic [15:0] m;
        bit          o;
    } res_t;

    vec_t        tbl[$];
    res_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] hold_mac = '0;
    logic [7:0]  exp8_mac;

    function automatic vec_t mk(input int n, input bit nv, input int w, input bit wv,
                                input bit clr, input bit last, input int exp_mac);
        vec_t v;
        v.n       = 4'(n);
        v.nv      = nv;
        v.w       = 4'(w);
        v.wv      = wv;
        v.clr     = clr;
        v.last    = last;
        v.exp_mac = 16'(exp_mac);
        v.exp_ovf = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one beat at a falling edge, sample #1 after the next rising edge.
    task automatic step(input vec_t v);
        bit   fire_last;
        res_t r;
        north     = v.n;
        north_vld = v.nv;
        west      = v.w;
        west_vld  = v.wv;
        west_clr  = v.clr;
        west_last = v.last;
        fire_last = v.nv & v.wv & v.last;
        if (fire_last) begin
            r.m = v.exp_mac;
            r.o = v.exp_ovf;
            sb.push_back(r);
        end
        @(posedge clk);
        #1;
        chk("south",     32'(south),     32'(v.n));
        chk("south_vld", 32'(south_vld), 32'(v.nv));
        chk("east",      32'(east),      32'(v.w));
        chk("east_vld",  32'(east_vld),  32'(v.wv));
        chk("east_clr",  32'(east_clr),  32'(v.clr));
        chk("east_last", 32'(east_last), 32'(v.last));
        chk("mac_vld",   32'(mac_vld),   32'(fire_last));
        if (mac_vld) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL mac_vld_unexpected: got pulse expected none (t=%0t)", $time);
            end else begin
                r = sb.pop_front();
                chk("mac",     32'(mac),     32'(r.m));
                chk("mac_ovf", 32'(mac_ovf), 32'(r.o));
                hold_mac = r.m;
            end
        end else begin
            chk("mac_hold", 32'(mac), 32'(hold_mac));
        end
        @(negedge clk);
    endtask

    initial begin
        reset_n   = 1'b0;
        north     = '0;
        west      = '0;
        north_vld = 1'b0;
        west_vld  = 1'b0;
        west_clr  = 1'b0;
        west_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_mac",     32'(mac),       32'd0);
        chk("rst_mac_vld", 32'(mac_vld),   32'd0);
        chk("rst_mac_ovf", 32'(mac_ovf),   32'd0);
        chk("rst_south",   32'(south_vld), 32'd0);
        reset_n = 1'b1;

        // 15*15 x4
        tbl.push_back(mk(15,1,15,1,1,0,0));
        tbl.push_back(mk(15,1,15,1,0,0,0));
        tbl.push_back(mk(15,1,15,1,0,0,0));
        tbl.push_back(mk(15,1,15,1,0,1,900));
        tbl.push_back(mk(0,0,0,0,0,0,0));
        // single-beat then back-to-back
        tbl.push_back(mk(7,1,9,1,1,1,63));
        tbl.push_back(mk(1,1,1,1,1,0,0));
        tbl.push_back(mk(2,1,3,1,0,1,7));
        tbl.push_back(mk(0,0,0,0,0,0,0));
        // stall: west invalid, its flags must be ignored
        tbl.push_back(mk(2,1,2,1,1,0,0));
        tbl.push_back(mk(6,1,5,0,1,1,0));
        tbl.push_back(mk(6,1,5,0,1,1,0));
        tbl.push_back(mk(6,1,5,0,1,1,0));
        tbl.push_back(mk(3,1,3,1,0,1,13));
        // restart from ACCUM with clr&last, then clr with zero product
        tbl.push_back(mk(5,1,10,1,1,0,0));
        tbl.push_back(mk(2,1,3,1,1,1,6));
        tbl.push_back(mk(5,1,10,1,1,0,0));
        tbl.push_back(mk(1,1,0,1,1,0,0));
        tbl.push_back(mk(2,1,3,1,0,1,6));
        // implicit start without clr; west-only beat does not fire
        tbl.push_back(mk(4,1,4,1,0,0,0));
        tbl.push_back(mk(1,1,1,1,0,1,17));
        tbl.push_back(mk(3,0,3,1,1,1,0));
        tbl.push_back(mk(0,0,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Overflow on the 8-bit instance: 225+225
        step(mk(15,1,15,1,1,0,0));
        step(mk(15,1,15,1,0,1,450));
`ifdef SYSTOLIC_PE_SAT_EN
        exp8_mac = 8'd255;
`else
        exp8_mac = 8'd194;
`endif
        chk("ovf8_vld", 32'(s8_mac_vld), 32'd1);
        chk("ovf8_mac", 32'(s8_mac),     32'(exp8_mac));
        chk("ovf8_ovf", 32'(s8_mac_ovf), 32'd1);
        step(mk(0,0,0,0,0,0,0));
        chk("ovf8_vld_drop", 32'(s8_mac_vld), 32'd0);
        chk("ovf8_hold",     32'(s8_mac),     32'(exp8_mac));

        // Sticky flag/clamp must survive a non-wrapping final beat
        step(mk(15,1,15,1,1,0,0));
        step(mk(15,1,15,1,0,0,0));
        step(mk(0,1,0,1,0,1,450));
        chk("sticky8_mac", 32'(s8_mac),     32'(exp8_mac));
        chk("sticky8_ovf", 32'(s8_mac_ovf), 32'd1);
        // Fresh dot product clears the overflow history
        step(mk(2,1,3,1,1,1,6));
        chk("clr8_mac", 32'(s8_mac),     32'd6);
        chk("clr8_ovf", 32'(s8_mac_ovf), 32'd0);

        // Reset mid dot product after 2 beats
        step(mk(3,1,3,1,1,0,0));
        step(mk(4,1,4,1,0,0,0));
        #2;
        reset_n = 1'b0;
        #1;
        chk("mrst_mac",       32'(mac),        32'd0);
        chk("mrst_mac_vld",   32'(mac_vld),    32'd0);
        chk("mrst_south",     32'(south),      32'd0);
        chk("mrst_south_vld", 32'(south_vld),  32'd0);
        chk("mrst_east",      32'(east),       32'd0);
        chk("mrst_east_vld",  32'(east_vld),   32'd0);
        chk("mrst8_mac",      32'(s8_mac),     32'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        hold_mac = '0;
        step(mk(3,1,5,1,1,0,0));
        step(mk(2,1,2,1,0,1,19));
        step(mk(0,0,0,0,0,0,0));

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
